serial_link_peer: RTL and testbench
===================================

Name: serial_link_peer

Overview:
- Cycle-level model of the far end of the DMG link cable: the responder to the DMG serial port (SB/SC).
- Shifts a byte out on SOUT→peer `sin` while shifting its own byte back on `sout`→DMG SIN, MSB first.
- Slave mode: follows the DMG-driven SCK. Master mode: generates SCK itself (DMG in external-clock mode).
- Sits in the testbench/system top beside the DMG core, fed by the same `clk`.

Parameters:
- CLK_DIV, 512, clk cycles per SCK half-period in master mode (≥2).
- TIMEOUT, 65536, clk cycles without an SCK edge before a slave transfer aborts. Used only with SERIAL_PEER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- nreset  in  1  reset, asynchronous, active-low
- mode_master  in  1  1 = peer generates SCK; sampled at transfer start
- sck_in  in  1  SCK pin as seen by peer (DMG-driven in slave mode)
- sck_out  out  1  generated SCK, idle high
- sck_oe  out  1  1 while the peer drives SCK
- sin  in  1  serial data from DMG SOUT
- sout  out  1  serial data to DMG SIN, idle high
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  peer can accept a tx byte
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  transfer in progress

Behaviour:
- Reset (async, nreset=0):
  - sout=1, sck_out=1, sck_oe=0, tx_ready=1, rx_valid=0, rx_data=0x00, busy=0.
  - Shift registers 0xFF; bit count 0; state IDLE.
  - Reset mid-transfer aborts immediately; no rx_valid.
- Input synchronisation:
  - sck_in and sin each pass through a 2-flop synchroniser with identical delay.
  - An edge is detected from sync stage 2 vs stage 3, so a pin edge acts 3 clk cycles later.
- States: IDLE, LOADED, SHIFT.
- IDLE:
  - tx_valid&&tx_ready loads tx_sr=tx_data; sout=tx_data[7] next cycle; go to LOADED.
  - A slave-mode falling SCK edge in IDLE starts a transfer with tx_sr=0xFF (open line); go to SHIFT.
- LOADED:
  - tx_ready=0.
  - Slave mode: wait for a falling edge.
  - Master mode: start the clock generator the next cycle; sck_oe=1.
- SHIFT:
  - busy=1, tx_ready=0.
  - Falling edge: sout=current MSB of tx_sr; tx_sr shifts left, filling 1.
  - Rising edge: rx_sr={rx_sr[6:0],sin_sync}; count+1.
  - After the 8th rising edge: rx_data=rx_sr (8 bits) and rx_valid=1 for one cycle the next cycle; sout=1; count=0; go to IDLE; tx_ready=1.
- First bit, slave mode: the DMG drives its bit on the falling edge, so the peer also updates sout on each falling edge; the first falling edge re-asserts bit 7.
- Master generator:
  - sck_out low for CLK_DIV cycles, then high for CLK_DIV cycles; 8 pulses.
  - Uses internal edges with no synchroniser delay; samples raw sin on the internal rising edge.
  - sck_oe drops one cycle after the 8th high phase begins.
- Counters: bit count 3-bit with carry flag; divider counter width $clog2(CLK_DIV).
- mode_master changes mid-transfer are ignored (latched at LOADED entry).
- Simultaneous rising and falling detection is impossible by construction. tx_valid during SHIFT is held off (tx_ready=0).
- The rx_valid pulse and a new tx handshake may occur in the same cycle.
- Glitches shorter than 1 clk on sck_in are not filtered beyond the synchroniser.

Optional Feature:
- SERIAL_PEER_TIMEOUT_EN defined:
  - In slave SHIFT/LOADED, a counter resets on each SCK edge.
  - Reaching TIMEOUT aborts to IDLE: sout=1, tx_ready=1, no rx_valid. A sticky `timeout_err` output is set, cleared by the next tx handshake.
- Undefined: no counter and no timeout_err port; the peer waits indefinitely.

Decomposition:
- Package serial_peer_pkg:
  - state enum (IDLE, LOADED, SHIFT)
  - SERIAL_BITS=8
  - IDLE_BYTE=8'hFF
  - SYNC_STAGES=2
- One sub-module, serial_peer_clkgen: CLK_DIV divider, pulse counter, sck_out/sck_oe, and one-cycle fall/rise strobes.

Test Plan:
- Slave, tx 0xA5 loaded; DMG clocks out 0x3C at 8192 Hz, 8 pulses → DMG receives 0xA5; rx_data=0x3C with a single rx_valid pulse 3 cycles after the 8th rising pin edge.
- Slave, no tx loaded; DMG clocks 0x00 → DMG receives 0xFF; rx_data=0x00.
- Master, CLK_DIV=4, tx 0x81; sin driven with 0x7E → exactly 8 sck_out pulses of 8 cycles each; rx_data=0x7E; sck_oe high only during the transfer.
- nreset pulsed low after the 4th rising edge → all outputs at reset values; no rx_valid; the next full transfer of 0x55 completes correctly.
- tx_valid held high during SHIFT with 0x12 → not accepted until tx_ready returns; accepted in the cycle after completion.
- With SERIAL_PEER_TIMEOUT_EN and TIMEOUT=100, clocking stops after 3 bits → abort at cycle 100 after the last edge; timeout_err=1; no rx_valid.

Source files
------------

// File: rtl/serial_peer_pkg.sv
// serial_peer_pkg
// Shared definitions for the DMG link-cable peer model.
//   peer_state_t : transfer state (IDLE, LOADED, SHIFT)
//   SERIAL_BITS  : bits per transfer
//   IDLE_BYTE    : value shifted out when no byte is loaded (open line)
//   SYNC_STAGES  : depth of the pin synchronisers
package serial_peer_pkg;

  localparam int SERIAL_BITS = 8;
  localparam logic [SERIAL_BITS-1:0] IDLE_BYTE = 8'hFF;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2
  } peer_state_t;

endpackage

// File: rtl/serial_peer_clkgen.sv
// serial_peer_clkgen
// SCK generator used when the peer is the clock master.
// Produces 8 SCK pulses (low CLK_DIV cycles, then high CLK_DIV cycles) and
// one-cycle strobes that follow each internal falling and rising transition.
// Ports:
//   clk, nreset : system clock, asynchronous active-low reset
//   i_start     : begin a burst of 8 pulses (ignored while active)
//   o_sck       : generated SCK, idle high
//   o_sckOe     : high while the generator owns the SCK line
//   o_fall      : one-cycle strobe after SCK goes low
//   o_rise      : one-cycle strobe after SCK goes high
module serial_peer_clkgen
  import serial_peer_pkg::*;
#(
  parameter int CLK_DIV = 512
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_start,
  output logic o_sck,
  output logic o_sckOe,
  output logic o_fall,
  output logic o_rise
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             r_active;
  logic             r_sck;
  logic             r_oe;
  logic             r_fall;
  logic             r_rise;
  logic             r_finish;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_pulseCnt;

  // The 8th rise sets r_finish; the line is released on the following
  // cycle, so sck_oe stays up for exactly one cycle of the last high phase.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_active   <= 1'b0;
      r_sck      <= 1'b1;
      r_oe       <= 1'b0;
      r_fall     <= 1'b0;
      r_rise     <= 1'b0;
      r_finish   <= 1'b0;
      r_div      <= '0;
      r_pulseCnt <= '0;
    end else begin
      r_fall <= 1'b0;
      r_rise <= 1'b0;
      if (!r_active) begin
        if (i_start) begin
          r_active   <= 1'b1;
          r_oe       <= 1'b1;
          r_sck      <= 1'b0;
          r_fall     <= 1'b1;
          r_div      <= '0;
          r_pulseCnt <= '0;
          r_finish   <= 1'b0;
        end
      end else if (r_finish) begin
        r_active   <= 1'b0;
        r_oe       <= 1'b0;
        r_finish   <= 1'b0;
        r_div      <= '0;
        r_pulseCnt <= '0;
      end else if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_sck <= ~r_sck;
        if (r_sck) begin
          r_fall <= 1'b1;
        end else begin
          r_rise <= 1'b1;
          if (r_pulseCnt == 3'(SERIAL_BITS - 1)) begin
            r_finish <= 1'b1;
          end else begin
            r_pulseCnt <= r_pulseCnt + 3'd1;
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign o_sck   = r_sck;
  assign o_sckOe = r_oe;
  assign o_fall  = r_fall;
  assign o_rise  = r_rise;

endmodule

// File: rtl/serial_link_peer.sv
// serial_link_peer
// Far end of the DMG link cable. Exchanges one byte per transfer with the DMG
// serial port, MSB first: sout is updated on falling SCK, sin is sampled on
// rising SCK. In slave mode it follows the DMG's SCK through a synchroniser;
// in master mode it drives SCK itself via serial_peer_clkgen.
// Ports:
//   clk, nreset       : system clock, asynchronous active-low reset
//   mode_master       : 1 = peer generates SCK (latched when a byte is loaded)
//   sck_in            : SCK pin as seen by the peer
//   sck_out, sck_oe   : generated SCK (idle high) and its drive enable
//   sin, sout         : data from DMG SOUT / data to DMG SIN (idle high)
//   tx_data/valid/ready : byte to send, handshake
//   rx_data, rx_valid : last received byte, one-cycle update pulse
//   busy              : transfer in progress
//   timeout_err       : sticky slave timeout flag (only with the macro below)
// Build option: define SERIAL_PEER_TIMEOUT_EN to abort a stalled slave
// transfer after TIMEOUT cycles without an SCK edge.
module serial_link_peer
  import serial_peer_pkg::*;
#(
  parameter int CLK_DIV = 512,
  parameter int TIMEOUT = 65536
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   mode_master,
  input  logic                   sck_in,
  output logic                   sck_out,
  output logic                   sck_oe,
  input  logic                   sin,
  output logic                   sout,
  input  logic [SERIAL_BITS-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [SERIAL_BITS-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   busy
`ifdef SERIAL_PEER_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  peer_state_t r_state;
  peer_state_t w_nextState;

  logic                   r_master;
  logic [SERIAL_BITS-1:0] r_txSr;
  logic [SERIAL_BITS-1:0] r_rxSr;
  logic [2:0]             r_bitCnt;
  logic                   r_sout;
  logic [SERIAL_BITS-1:0] r_rxData;
  logic                   r_rxValid;

  // Index 0..SYNC_STAGES-1 is the synchroniser, the extra top flop is only
  // used for edge detection.
  logic [SYNC_STAGES:0]   r_sckSync;
  logic [SYNC_STAGES-1:0] r_sinSync;

  logic       w_syncFall;
  logic       w_syncRise;
  logic       w_genFall;
  logic       w_genRise;
  logic       w_genStart;
  logic       w_fall;
  logic       w_rise;
  logic       w_sinSample;
  logic       w_txHandshake;
  logic [3:0] w_cntSum;
  logic       w_carry;
  logic       w_done;
  logic       w_timeout;

  // Pin synchronisers; both reset to the idle-high line level so that
  // leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sckSync <= '1;
      r_sinSync <= '1;
    end else begin
      r_sckSync <= {r_sckSync[SYNC_STAGES-1:0], sck_in};
      r_sinSync <= {r_sinSync[SYNC_STAGES-2:0], sin};
    end
  end

  assign w_syncFall = r_sckSync[SYNC_STAGES] & ~r_sckSync[SYNC_STAGES-1];
  assign w_syncRise = ~r_sckSync[SYNC_STAGES] & r_sckSync[SYNC_STAGES-1];

  serial_peer_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .nreset (nreset),
    .i_start(w_genStart),
    .o_sck  (sck_out),
    .o_sckOe(sck_oe),
    .o_fall (w_genFall),
    .o_rise (w_genRise)
  );

  // In master mode the internal strobes already line up with the generated
  // clock, so raw sin is sampled rather than the synchronised copy.
  assign w_fall      = r_master ? w_genFall : w_syncFall;
  assign w_rise      = r_master ? w_genRise : w_syncRise;
  assign w_sinSample = r_master ? sin : r_sinSync[SYNC_STAGES-1];

  assign w_txHandshake = tx_valid && (r_state == IDLE);
  assign w_cntSum      = {1'b0, r_bitCnt} + 4'd1;
  assign w_carry       = w_cntSum[3];
  assign w_done        = (r_state == SHIFT) && w_rise && w_carry;

`ifdef SERIAL_PEER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_toCnt;
  logic            r_timeoutErr;
  logic            w_slaveWait;
  logic            w_anyEdge;

  assign w_slaveWait = !r_master && ((r_state == LOADED) || (r_state == SHIFT));
  assign w_anyEdge   = w_syncFall | w_syncRise;
  assign w_timeout   = w_slaveWait && !w_anyEdge && (r_toCnt == TO_W'(TIMEOUT - 1));

  // Idle-time counter, restarted by every SCK edge while a slave transfer
  // is pending or running.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_toCnt <= '0;
    end else if (!w_slaveWait || w_anyEdge) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + TO_W'(1);
    end
  end

  // Sticky error flag; the next accepted byte clears it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_timeoutErr <= 1'b0;
    end else if (w_timeout) begin
      r_timeoutErr <= 1'b1;
    end else if (w_txHandshake) begin
      r_timeoutErr <= 1'b0;
    end
  end

  assign timeout_err = r_timeoutErr;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT > 0);
  assign w_timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Master transfers leave LOADED unconditionally: the generator is started
  // in that cycle and its first strobe arrives once we are in SHIFT.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_txHandshake) begin
          w_nextState = LOADED;
        end else if (!mode_master && w_syncFall) begin
          w_nextState = SHIFT;
        end
      end
      LOADED: begin
        if (w_timeout) begin
          w_nextState = IDLE;
        end else if (r_master || w_fall) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (w_timeout || w_done) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    tx_ready   = 1'b0;
    busy       = 1'b0;
    w_genStart = 1'b0;
    unique case (r_state)
      IDLE:    tx_ready   = 1'b1;
      LOADED:  w_genStart = r_master;
      SHIFT:   busy       = 1'b1;
      default: tx_ready   = 1'b0;
    endcase
  end

  // Shift datapath. A falling edge always presents the current MSB, so the
  // first falling edge of a transfer re-drives bit 7 already on sout.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_master  <= 1'b0;
      r_txSr    <= IDLE_BYTE;
      r_rxSr    <= IDLE_BYTE;
      r_bitCnt  <= '0;
      r_sout    <= 1'b1;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_txHandshake) begin
            r_txSr   <= tx_data;
            r_sout   <= tx_data[SERIAL_BITS-1];
            r_master <= mode_master;
            r_bitCnt <= '0;
          end else if (!mode_master && w_syncFall) begin
            r_txSr   <= {IDLE_BYTE[SERIAL_BITS-2:0], 1'b1};
            r_sout   <= IDLE_BYTE[SERIAL_BITS-1];
            r_master <= 1'b0;
            r_bitCnt <= '0;
          end
        end
        LOADED: begin
          if (w_timeout) begin
            r_sout   <= 1'b1;
            r_txSr   <= IDLE_BYTE;
            r_bitCnt <= '0;
          end else if (!r_master && w_fall) begin
            r_sout <= r_txSr[SERIAL_BITS-1];
            r_txSr <= {r_txSr[SERIAL_BITS-2:0], 1'b1};
          end
        end
        SHIFT: begin
          if (w_timeout) begin
            r_sout   <= 1'b1;
            r_txSr   <= IDLE_BYTE;
            r_bitCnt <= '0;
          end else if (w_fall) begin
            r_sout <= r_txSr[SERIAL_BITS-1];
            r_txSr <= {r_txSr[SERIAL_BITS-2:0], 1'b1};
          end else if (w_rise) begin
            r_rxSr   <= {r_rxSr[SERIAL_BITS-2:0], w_sinSample};
            r_bitCnt <= w_cntSum[2:0];
            if (w_carry) begin
              r_rxData  <= {r_rxSr[SERIAL_BITS-2:0], w_sinSample};
              r_rxValid <= 1'b1;
              r_sout    <= 1'b1;
              r_bitCnt  <= '0;
            end
          end
        end
        default: begin
          r_sout <= 1'b1;
        end
      endcase
    end
  end

  assign sout     = r_sout;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;

endmodule

// File: tb/tb_serial_link_peer.sv
// tb_serial_link_peer
// Self-checking bench for serial_link_peer. A byte-level DMG model drives the
// cable in both clocking modes; expected bytes are queued when stimulus is
// issued and popped by a monitor when rx_valid fires.
module tb_serial_link_peer;

  localparam int TB_CLK_DIV = 4;

  logic       clk;
  logic       nreset;
  logic       mode_master;
  logic       sck_in;
  logic       sck_out;
  logic       sck_oe;
  logic       sin;
  logic       sout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
`ifdef SERIAL_PEER_TIMEOUT_EN
  logic       timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rxExpQ[$];
  logic [7:0] dmgExpQ[$];

  serial_link_peer #(
    .CLK_DIV(TB_CLK_DIV)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .mode_master(mode_master),
    .sck_in     (sck_in),
    .sck_out    (sck_out),
    .sck_oe     (sck_oe),
    .sin        (sin),
    .sout       (sout),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
`ifdef SERIAL_PEER_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_sout", 32'(sout), 32'd1);
    checkOutput("rst_sck_out", 32'(sck_out), 32'd1);
    checkOutput("rst_sck_oe", 32'(sck_oe), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
  endtask

  // Offer a byte and wait for it to be taken; optionally queue it as what
  // the DMG should receive next.
  task automatic applyStimulus(input logic [7:0] data, input bit pushExp);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) checkOutput("tx_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("tx_taken", 32'(tx_ready), 32'd0);
    checkOutput("sout_msb", 32'(sout), 32'(data[7]));
    if (pushExp) dmgExpQ.push_back(data);
  endtask

  // DMG as clock master: drives its bit on SCK fall, samples sout on rise.
  task automatic dmgSlave(input logic [7:0] outByte, input int nBits, input int half);
    logic [7:0] got;
    logic [7:0] expByte;
    got = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      sck_in = 1'b0;
      sin    = outByte[7-i];
      repeat (half) @(negedge clk);
      if (i == 0) checkOutput("busy_shift", 32'(busy), 32'd1);
      sck_in = 1'b1;
      got    = {got[6:0], sout};
      if (i != nBits - 1) repeat (half) @(negedge clk);
    end
    if (nBits == 8) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checkOutput("rx_valid_latency", 32'(rx_valid), 32'(k == 3));
      end
      if (dmgExpQ.size() == 0) begin
        checkOutput("dmg_rx_unexpected", 32'(got), 32'hFFFF);
      end else begin
        expByte = dmgExpQ.pop_front();
        checkOutput("dmg_rx", 32'(got), 32'(expByte));
      end
    end
    sin = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // DMG in external-clock mode: follows the peer's SCK, checks its shape.
  task automatic dmgExt(input logic [7:0] outByte, input bit flipMode);
    logic [7:0] got;
    logic [7:0] expByte;
    logic       prevSck;
    bit         seenOe;
    bit         done;
    int         pulses, badPhase, lowLen, highLen, oeLen;
    got = 8'h00; prevSck = 1'b1; seenOe = 0; done = 0;
    pulses = 0; badPhase = 0; lowLen = 0; highLen = 0; oeLen = 0;
    for (int cyc = 0; cyc < 40 * TB_CLK_DIV + 100 && !done; cyc++) begin
      @(negedge clk);
      if (sck_oe) begin
        seenOe = 1;
        oeLen++;
      end else if (seenOe) begin
        done = 1;
      end
      if (prevSck && !sck_out) begin
        if (pulses > 0 && highLen != TB_CLK_DIV) badPhase++;
        pulses++;
        lowLen = 0;
        if (pulses <= 8) sin = outByte[8-pulses];
        if (flipMode && pulses == 3) mode_master = 1'b0;
      end
      if (!prevSck && sck_out) begin
        if (lowLen != TB_CLK_DIV) badPhase++;
        got     = {got[6:0], sout};
        highLen = 0;
      end
      if (!sck_out) lowLen++;
      else highLen++;
      prevSck = sck_out;
    end
    checkOutput("ext_done", 32'(done), 32'd1);
    checkOutput("ext_pulses", 32'(pulses), 32'd8);
    checkOutput("ext_phase_len", 32'(badPhase), 32'd0);
    checkOutput("ext_oe_len", 32'(oeLen), 32'(15 * TB_CLK_DIV + 1));
    checkOutput("ext_sck_idle", 32'(sck_out), 32'd1);
    if (dmgExpQ.size() == 0) begin
      checkOutput("dmg_rx_unexpected", 32'(got), 32'hFFFF);
    end else begin
      expByte = dmgExpQ.pop_front();
      checkOutput("dmg_rx", 32'(got), 32'(expByte));
    end
    sin = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every rx_valid pulse must match the oldest queued byte.
  initial begin
    logic [7:0] expByte;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rxExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rx_valid_unexpected actual=%0h required=none", rx_data);
        end else begin
          expByte = rxExpQ.pop_front();
          checkOutput("rx_data", 32'(rx_data), 32'(expByte));
        end
      end
    end
  end

  initial begin
    logic [7:0] b, t;
    int half, n;
    nreset = 1'b0; mode_master = 1'b0; sck_in = 1'b1; sin = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkReset();
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] slave transfer, byte loaded");
    applyStimulus(8'hA5, 1);
    rxExpQ.push_back(8'h3C);
    dmgSlave(8'h3C, 8, 16);
    checkOutput("idle_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] slave transfer, nothing loaded");
    dmgExpQ.push_back(8'hFF);
    rxExpQ.push_back(8'h00);
    dmgSlave(8'h00, 8, 12);

    $display("[TB] random slave transfers");
    for (int it = 0; it < 6; it++) begin
      b    = 8'($urandom);
      t    = 8'($urandom);
      half = int'($urandom_range(6, 20));
      if ($urandom_range(0, 1) == 1) applyStimulus(t, 1);
      else dmgExpQ.push_back(8'hFF);
      rxExpQ.push_back(b);
      dmgSlave(b, 8, half);
    end

    $display("[TB] master transfers");
    mode_master = 1'b1;
    applyStimulus(8'h81, 1);
    rxExpQ.push_back(8'h7E);
    dmgExt(8'h7E, 1);
    mode_master = 1'b1;
    for (int it = 0; it < 2; it++) begin
      b = 8'($urandom);
      t = 8'($urandom);
      applyStimulus(t, 1);
      rxExpQ.push_back(b);
      dmgExt(b, 0);
    end
    mode_master = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] reset during transfer");
    applyStimulus(8'hC3, 0);
    dmgSlave(8'h99, 4, 10);
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    checkReset();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    b = 8'($urandom);
    applyStimulus(8'h55, 1);
    rxExpQ.push_back(b);
    dmgSlave(b, 8, 10);

    $display("[TB] tx_valid held during shift");
    b = 8'($urandom);
    applyStimulus(8'h66, 1);
    rxExpQ.push_back(b);
    fork
      dmgSlave(b, 8, 10);
      begin : heldBranch
        n = 0;
        while (!busy && n < 500) begin
          @(negedge clk);
          n++;
        end
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        n = 0;
        while (n < 2000) begin
          @(negedge clk);
          n++;
          if (tx_ready) break;
        end
        checkOutput("held_accept_at_done", 32'(rx_valid), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("held_taken", 32'(tx_ready), 32'd0);
        checkOutput("held_sout_msb", 32'(sout), 32'd0);
        dmgExpQ.push_back(8'h12);
      end
    join
    b = 8'($urandom);
    rxExpQ.push_back(b);
    dmgSlave(b, 8, 8);

    repeat (10) @(negedge clk);
    checkOutput("rx_queue_empty", 32'(rxExpQ.size()), 32'd0);
    checkOutput("dmg_queue_empty", 32'(dmgExpQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
